// File: rtl/cp0_intc.sv
// Coprocessor-0 interrupt/exception receiver: holds SR, Cause, EPC and PRId,
// raises req for the M-stage flush/redirect and supplies EPC for eret.
module cp0_intc #(
  parameter logic [31:0] PRID      = 32'h0000_4D50,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  cp0_ra,
  input  logic [4:0]  cp0_wa,
  input  logic [31:0] cp0_wd,
  input  logic        cp0_we,
  input  logic [29:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code_m,
  input  logic        eret_m,
  input  logic [5:0]  hw_int,
  output logic [31:0] cp0_rd,
  output logic        req,
  output logic [29:0] epc,
  output logic [31:0] handler_pc
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [29:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  assign int_req    = ie_q & ~exl_q & (|(hw_int & im_q));
  assign exc_req    = ~exl_q & (exc_code_m != 5'd0);
  assign req        = int_req | exc_req;
  assign epc        = epc_q;
  assign handler_pc = EXC_ENTRY;

  assign sr_val    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_val = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};

  always_comb begin
    cp0_rd = 32'b0;
    case (cp0_ra)
      REG_SR:    cp0_rd = sr_val;
      REG_CAUSE: cp0_rd = cause_val;
      REG_EPC:   cp0_rd = {epc_q, 2'b0};
      REG_PRID:  cp0_rd = PRID;
      default:   cp0_rd = 32'b0;
    endcase
  end

  // Entry beats eret, which beats mtc0; an interrupt wins ExcCode over a
  // simultaneous exception by recording code 0.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = hw_int;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (req) begin
      exl_d      = 1'b1;
      bd_d       = bd_m;
      epc_d      = bd_m ? (pc_m - 30'd1) : pc_m;
      exc_code_d = int_req ? 5'd0 : exc_code_m;
    end else if (eret_m) begin
      exl_d = 1'b0;
    end else if (cp0_we) begin
      case (cp0_wa)
        REG_SR: begin
          im_d  = cp0_wd[15:10];
          exl_d = cp0_wd[1];
          ie_d  = cp0_wd[0];
        end
        REG_EPC: epc_d = cp0_wd[31:2];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q       <= 6'b0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'b0;
      exc_code_q <= 5'b0;
      epc_q      <= 30'b0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_intc.sv
// Bench for cp0_intc: a hand-derived vector table for the directed scenarios,
// then random stimulus checked against a register-image reference model.
module tb_cp0_intc;

  logic        clk;
  logic        reset;
  logic [4:0]  cp0_ra;
  logic [4:0]  cp0_wa;
  logic [31:0] cp0_wd;
  logic        cp0_we;
  logic [29:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic        eret_m;
  logic [5:0]  hw_int;
  logic [31:0] cp0_rd;
  logic        req;
  logic [29:0] epc;
  logic [31:0] handler_pc;

  cp0_intc dut (
    .clk(clk), .reset(reset), .cp0_ra(cp0_ra), .cp0_wa(cp0_wa), .cp0_wd(cp0_wd),
    .cp0_we(cp0_we), .pc_m(pc_m), .bd_m(bd_m), .exc_code_m(exc_code_m),
    .eret_m(eret_m), .hw_int(hw_int), .cp0_rd(cp0_rd), .req(req), .epc(epc),
    .handler_pc(handler_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ra;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we;
    logic [29:0] pc;
    logic        bd;
    logic [4:0]  code;
    logic        eret;
    logic [5:0]  hw;
    logic        exp_req;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference state kept as full 32-bit register images.
  logic [31:0] m_sr, m_cause, m_epc;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] ra, input logic [4:0] wa,
                              input logic [31:0] wd, input logic we,
                              input logic [29:0] pc, input logic bd,
                              input logic [4:0] code, input logic eret,
                              input logic [5:0] hw, input logic exp_req,
                              input logic [31:0] exp_rd);
    vec_t v;
    v.ra = ra; v.wa = wa; v.wd = wd; v.we = we; v.pc = pc; v.bd = bd;
    v.code = code; v.eret = eret; v.hw = hw; v.exp_req = exp_req; v.exp_rd = exp_rd;
    return v;
  endfunction

  function automatic logic [31:0] model_rd(input logic [4:0] ra);
    case (ra)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_4D50;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic model_int(input logic [5:0] hw);
    return m_sr[0] && !m_sr[1] && ((hw & m_sr[15:10]) != 6'd0);
  endfunction

  function automatic logic model_req(input vec_t v);
    return model_int(v.hw) || (!m_sr[1] && v.code != 5'd0);
  endfunction

  task automatic model_reset();
    m_sr = 32'h0; m_cause = 32'h0; m_epc = 32'h0;
  endtask

  task automatic model_clock(input vec_t v);
    logic [31:0] pc_byte;
    logic        take_int;
    pc_byte  = {v.pc, 2'b00};
    take_int = model_int(v.hw);
    if (model_req(v)) begin
      m_sr[1] = 1'b1;
      m_cause = {v.bd, 24'h0, 5'd0, 2'b00};
      m_cause[6:2] = take_int ? 5'd0 : v.code;
      m_epc = v.bd ? pc_byte - 32'd4 : pc_byte;
    end else if (v.eret) begin
      m_sr[1] = 1'b0;
    end else if (v.we) begin
      if (v.wa == 5'd12) m_sr = v.wd & 32'h0000_FC03;
      else if (v.wa == 5'd14) m_epc = v.wd & 32'hFFFF_FFFC;
    end
    m_cause[15:10] = v.hw;
  endtask

  task automatic drive(input vec_t v);
    cp0_ra = v.ra; cp0_wa = v.wa; cp0_wd = v.wd; cp0_we = v.we;
    pc_m = v.pc; bd_m = v.bd; exc_code_m = v.code; eret_m = v.eret; hw_int = v.hw;
  endtask

  // Drive at the falling edge, check mid-cycle, then clock the model along.
  task automatic apply_stimulus(input vec_t v, input bit use_table);
    drive(v);
    #1;
    if (use_table) begin
      check_output("req", {31'b0, req}, {31'b0, v.exp_req});
      check_output($sformatf("cp0_rd[%0d]", v.ra), cp0_rd, v.exp_rd);
    end else begin
      check_output("req_rand", {31'b0, req}, {31'b0, model_req(v)});
      check_output($sformatf("cp0_rd_rand[%0d]", v.ra), cp0_rd, model_rd(v.ra));
    end
    check_output("epc_port", {2'b0, epc}, {2'b0, m_epc[31:2]});
    @(posedge clk);
    model_clock(v);
    @(negedge clk);
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 5))
      0: return 5'd12;
      1: return 5'd13;
      2: return 5'd14;
      3: return 5'd15;
      4: return 5'd7;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    vec_t idle;
    vec_t rv;
    logic [4:0] reset_regs[5];
    logic [31:0] reset_exp[5];

    idle = mk(5'd0, 5'd0, 32'h0, 1'b0, 30'h0, 1'b0, 5'd0, 1'b0, 6'h0, 1'b0, 32'h0);
    reset = 1'b0;
    drive(idle);
    model_reset();

    // Reads while reset is held low
    reset_regs = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd7};
    reset_exp  = '{32'h0, 32'h0, 32'h0, 32'h0000_4D50, 32'h0};
    @(negedge clk);
    hw_int = 6'h3F;
    for (int i = 0; i < 5; i++) begin
      cp0_ra = reset_regs[i];
      #1;
      check_output($sformatf("reset_rd[%0d]", reset_regs[i]), cp0_rd, reset_exp[i]);
    end
    check_output("reset_req", {31'b0, req}, 32'h0);
    check_output("handler_pc", handler_pc, 32'h0000_4180);
    @(negedge clk);
    reset = 1'b1;
    hw_int = 6'h0;

    //               ra     wa     wd            we    pc        bd    code  eret  hw     req   rd
    vecs.push_back(mk(5'd12, 5'd12, 32'h0000_0401, 1'b1, 30'h0,    1'b0, 5'd0,  1'b0, 6'h00, 1'b0, 32'h0));
    vecs.push_back(mk(5'd12, 5'd0,  32'h0,         1'b0, 30'h0C00, 1'b0, 5'd0,  1'b0, 6'h01, 1'b1, 32'h0000_0401));
    vecs.push_back(mk(5'd12, 5'd0,  32'h0,         1'b0, 30'h0C01, 1'b0, 5'd0,  1'b0, 6'h01, 1'b0, 32'h0000_0403));
    vecs.push_back(mk(5'd13, 5'd0,  32'h0,         1'b0, 30'h0C02, 1'b0, 5'd0,  1'b0, 6'h01, 1'b0, 32'h0000_0400));
    vecs.push_back(mk(5'd14, 5'd0,  32'h0,         1'b0, 30'h0C03, 1'b0, 5'd0,  1'b0, 6'h01, 1'b0, 32'h0000_3000));
    vecs.push_back(mk(5'd12, 5'd0,  32'h0,         1'b0, 30'h0C04, 1'b0, 5'd0,  1'b1, 6'h01, 1'b0, 32'h0000_0403));
    vecs.push_back(mk(5'd12, 5'd0,  32'h0,         1'b0, 30'h0D00, 1'b0, 5'd0,  1'b0, 6'h01, 1'b1, 32'h0000_0401));
    vecs.push_back(mk(5'd14, 5'd0,  32'h0,         1'b0, 30'h0D01, 1'b0, 5'd0,  1'b0, 6'h00, 1'b0, 32'h0000_3400));
    vecs.push_back(mk(5'd13, 5'd0,  32'h0,         1'b0, 30'h0D02, 1'b0, 5'd0,  1'b1, 6'h00, 1'b0, 32'h0));
    vecs.push_back(mk(5'd12, 5'd12, 32'h0000_0400, 1'b1, 30'h0D03, 1'b0, 5'd0,  1'b0, 6'h00, 1'b0, 32'h0000_0401));
    vecs.push_back(mk(5'd12, 5'd0,  32'h0,         1'b0, 30'h0C03, 1'b1, 5'd4,  1'b0, 6'h00, 1'b1, 32'h0000_0400));
    vecs.push_back(mk(5'd13, 5'd0,  32'h0,         1'b0, 30'h0C04, 1'b0, 5'd0,  1'b0, 6'h00, 1'b0, 32'h8000_0010));
    vecs.push_back(mk(5'd14, 5'd0,  32'h0,         1'b0, 30'h0C05, 1'b0, 5'd0,  1'b0, 6'h00, 1'b0, 32'h0000_3008));
    vecs.push_back(mk(5'd12, 5'd0,  32'h0,         1'b0, 30'h0C06, 1'b0, 5'd4,  1'b0, 6'h00, 1'b0, 32'h0000_0402));
    vecs.push_back(mk(5'd12, 5'd0,  32'h0,         1'b0, 30'h0C07, 1'b0, 5'd0,  1'b1, 6'h00, 1'b0, 32'h0000_0402));
    vecs.push_back(mk(5'd13, 5'd12, 32'h0000_0401, 1'b1, 30'h0C08, 1'b0, 5'd0,  1'b0, 6'h00, 1'b0, 32'h8000_0010));
    vecs.push_back(mk(5'd14, 5'd14, 32'hDEAD_BEEC, 1'b1, 30'h0E00, 1'b0, 5'd10, 1'b0, 6'h01, 1'b1, 32'h0000_3008));
    vecs.push_back(mk(5'd14, 5'd0,  32'h0,         1'b0, 30'h0E01, 1'b0, 5'd0,  1'b0, 6'h00, 1'b0, 32'h0000_3800));
    vecs.push_back(mk(5'd13, 5'd0,  32'h0,         1'b0, 30'h0E02, 1'b0, 5'd0,  1'b0, 6'h00, 1'b0, 32'h0));
    vecs.push_back(mk(5'd15, 5'd0,  32'h0,         1'b0, 30'h0E03, 1'b0, 5'd0,  1'b0, 6'h00, 1'b0, 32'h0000_4D50));
    vecs.push_back(mk(5'd12, 5'd0,  32'h0,         1'b0, 30'h0E04, 1'b0, 5'd0,  1'b1, 6'h00, 1'b0, 32'h0000_0403));
    vecs.push_back(mk(5'd14, 5'd14, 32'h1234_5677, 1'b1, 30'h0E05, 1'b0, 5'd0,  1'b0, 6'h00, 1'b0, 32'h0000_3800));
    vecs.push_back(mk(5'd14, 5'd13, 32'hFFFF_FFFF, 1'b1, 30'h0E06, 1'b0, 5'd0,  1'b0, 6'h00, 1'b0, 32'h1234_5674));
    vecs.push_back(mk(5'd13, 5'd15, 32'hFFFF_FFFF, 1'b1, 30'h0E07, 1'b0, 5'd0,  1'b0, 6'h00, 1'b0, 32'h0));
    vecs.push_back(mk(5'd15, 5'd0,  32'h0,         1'b0, 30'h0E08, 1'b0, 5'd0,  1'b0, 6'h00, 1'b0, 32'h0000_4D50));
    vecs.push_back(mk(5'd14, 5'd0,  32'h0,         1'b0, 30'h0,    1'b1, 5'd8,  1'b0, 6'h00, 1'b1, 32'h1234_5674));
    vecs.push_back(mk(5'd14, 5'd0,  32'h0,         1'b0, 30'h0E09, 1'b0, 5'd0,  1'b0, 6'h00, 1'b0, 32'hFFFF_FFFC));
    vecs.push_back(mk(5'd13, 5'd14, 32'h0,         1'b1, 30'h0E0A, 1'b0, 5'd0,  1'b1, 6'h00, 1'b0, 32'h8000_0020));
    vecs.push_back(mk(5'd14, 5'd0,  32'h0,         1'b0, 30'h0E0B, 1'b0, 5'd0,  1'b0, 6'h00, 1'b0, 32'hFFFF_FFFC));
    vecs.push_back(mk(5'd12, 5'd0,  32'h0,         1'b0, 30'h0100, 1'b0, 5'd0,  1'b0, 6'h01, 1'b1, 32'h0000_0401));

    foreach (vecs[i]) apply_stimulus(vecs[i], 1'b1);

    // Reset pulse between edges while EXL=1 must clear state immediately
    cp0_ra = 5'd12;
    hw_int = 6'h0;
    #1 reset = 1'b0;
    #1 check_output("async_rst_sr", cp0_rd, 32'h0);
    cp0_ra = 5'd13;
    #1 check_output("async_rst_cause", cp0_rd, 32'h0);
    cp0_ra = 5'd14;
    #1 check_output("async_rst_epc", cp0_rd, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 400; i++) begin
      rv = idle;
      rv.ra   = pick_reg();
      rv.we   = ($urandom_range(0, 3) == 0);
      rv.wa   = pick_reg();
      rv.wd   = $urandom();
      rv.pc   = 30'($urandom());
      rv.bd   = 1'($urandom_range(0, 1));
      rv.code = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      rv.eret = ($urandom_range(0, 7) == 0);
      rv.hw   = ($urandom_range(0, 1) == 0) ? 6'h0 : 6'($urandom_range(0, 63));
      apply_stimulus(rv, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cp0_intc.md
Name: cp0_intc

Overview:
- Coprocessor-0 interrupt/exception receiver on the CPU side of the Pr interface.
- It consumes the HWInt[7:2] lines driven by the Bridge from the Timer IRQs, and the synchronous exception codes from the pipeline.
- It decides whether to take an interrupt or exception, latches SR/Cause/EPC, and presents EPC for eret.
- It sits in the M stage of the CPU, alongside the Bridge-facing store path.

Parameters:
- PRID, 32'h0000_4D50, constant value returned for PRId (reg 15).
- EXC_ENTRY, 32'h0000_4180, handler entry address driven on handler_pc.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cp0_ra  in  5  mfc0 register address.
- cp0_wa  in  5  mtc0 register address.
- cp0_wd  in  32  mtc0 write data.
- cp0_we  in  1  mtc0 write enable.
- pc_m  in  30  word PC [31:2] of the M-stage instruction.
- bd_m  in  1  M-stage instruction is in a branch delay slot.
- exc_code_m  in  5  ExcCode [6:2] of M stage; 0 means no exception.
- eret_m  in  1  eret in M stage.
- hw_int  in  6  HWInt[7:2] from the Bridge.
- cp0_rd  out  32  mfc0 read data.
- req  out  1  take interrupt/exception this cycle (flush + redirect).
- epc  out  30  current EPC [31:2].
- handler_pc  out  32  EXC_ENTRY.

Behaviour:
- Registers:
  - SR(12) = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}.
  - Cause(13) = {BD[31], 15'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}.
  - EPC(14) = {epc, 2'b0}.
  - PRId(15) = PRID.
- Reset (reset=0, asynchronous):
  - IM, EXL, IE, BD, IP, ExcCode, epc all 0.
  - Outputs: req=0, cp0_rd=mux of reset registers.
- Combinational:
  - int_req = IE & ~EXL & |(hw_int & IM).
  - exc_req = ~EXL & (exc_code_m != 0).
  - req = int_req | exc_req.
  - cp0_rd = register selected by cp0_ra; unlisted addresses read 0.
  - No internal read bypass of same-cycle writes (the pipeline forwards).
- IP[15:10] <= hw_int every cycle, regardless of EXL/IE.
- Update priority on each rising edge (highest first):
  1. req=1:
     - EXL<=1; BD<=bd_m.
     - epc <= bd_m ? pc_m-1 : pc_m (i.e. byte address PC-4 when in a delay slot).
     - ExcCode <= int_req ? 0 : exc_code_m. Interrupt beats simultaneous exception.
     - Any mtc0 or eret in the same cycle is dropped.
  2. eret_m=1: EXL<=0. A concurrent mtc0 (not generated by the ISA) is ignored.
  3. cp0_we=1, by cp0_wa:
     - 12 writes IM/EXL/IE from cp0_wd[15:10], [1], [0].
     - 14 writes epc <= cp0_wd[31:2].
     - 13, 15 and others: no effect (Cause and PRId are read-only to software).
- Width and arithmetic rules:
  - pc_m-1 wraps modulo 2^30 (pc_m=0 gives 30'h3FFF_FFFF).
  - cp0_wd[1:0] for EPC is discarded.
- EXL=1 masks all further int_req/exc_req; nesting is impossible until eret.
- Latency:
  - req is same-cycle combinational.
  - State is visible on cp0_rd the cycle after the edge.
- hw_int is level-sensitive. CP0 does not clear it; software clears the Timer.
  - If still asserted after eret, req reasserts once EXL=0.
- Reset asserted mid-handler (EXL=1) clears EXL immediately, without waiting for a clock edge.

Test Plan:
- Reset then mfc0 each register:
  - reset=0 → cp0_rd(12)=0, (13)=0, (14)=0, (15)=32'h00004D50, (7)=0.
  - req=0 with hw_int=6'h3F.
- Interrupt entry:
  - Setup: mtc0 SR=32'h0000_0401; hw_int=6'b000001; pc_m=30'h0C00; bd_m=0.
  - Response: req=1 that cycle; after edge SR=32'h0000_0403.
  - Cause=32'h0000_0400 (ExcCode 0); EPC=32'h0000_3000.
  - req stays 0 next cycle despite hw_int held.
- Delay-slot exception:
  - Setup: SR.IE=0; exc_code_m=5'd4; bd_m=1; pc_m=30'h0C03.
  - Response: req=1; Cause=32'h8000_0010; EPC=32'h0000_3008.
- Simultaneous interrupt + exception + mtc0:
  - Setup: IM[10]=1, IE=1, hw_int[2]=1, exc_code_m=10, cp0_we=1 to EPC with 32'hDEAD_BEEC.
  - Response: ExcCode=0; EPC=pc_m; mtc0 discarded.
- eret with hw_int still asserted:
  - EXL 1→0 after the edge.
  - req=1 the following cycle; EPC updated to the new pc_m.
- Asynchronous reset mid-handler:
  - With EXL=1, pulse reset low between clock edges.
  - SR/Cause/EPC read 0 before the next rising edge.
